serial_slave_responder: RTL and testbench

- Responder end of the bit-serial bus: the slave-side interface that answers the serial address/data streams the masters drive through the arbiter.
- Deserialises the address, then either deserialises write data into a local register file or serialises read data back towards the arbiter.
- Sits in an arbiter slave slot (s1/s2/s3), pin-compatible with the existing slave wiring.

---
 rtl/serial_slave_responder.sv | 155 +++++++++++++++
 tb/tb_serial_slave_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_slave_responder.sv
// Slave-side responder of the bit-serial bus: deserialises address and write data into a
// small register file, or serialises a stored word back out while the arbiter grants the bus.
module serial_slave_responder #(
    parameter int MemN   = 2,
    parameter int N      = 8,
    parameter int DelayN = 20,
    parameter int ADN    = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       validIn,
    input  logic       wren,
    input  logic       Address,
    input  logic       DataIn,
    input  logic       BusAvailable,
    output logic       ready,
    output logic       validOut,
    output logic       DataOut,
    output logic [3:0] state_out
);

    localparam int Depth    = 1 << MemN;
    localparam int CntMax   = (ADN > N) ? ADN : N;
    localparam int CW       = $clog2(CntMax + 1);
    localparam int WaitLast = (DelayN > 0) ? DelayN - 1 : 0;
    localparam int WW       = (WaitLast > 0) ? $clog2(WaitLast + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ADDR  = 4'd1,
        S_WDATA = 4'd2,
        S_WAIT  = 4'd3,
        S_RDATA = 4'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     bitCnt_q, bitCnt_d;
    logic [MemN-1:0]   addr_q, addr_d;
    logic              wren_q, wren_d;
    logic [N-1:0]      data_q, data_d;
    logic [WW-1:0]     waitCnt_q, waitCnt_d;
    logic [N-1:0]      rdShift_q, rdShift_d;
    logic              validOut_q, validOut_d;
    logic              dataOut_q, dataOut_d;
    logic              memWe;
    logic [N-1:0]      mem_q [Depth];

    // The shared bit counter indexes address bits, write-data bits and read bits in turn.
    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        addr_d     = addr_q;
        wren_d     = wren_q;
        data_d     = data_q;
        waitCnt_d  = waitCnt_q;
        rdShift_d  = rdShift_q;
        validOut_d = 1'b0;
        dataOut_d  = 1'b0;
        memWe      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (validIn) begin
                    addr_d    = '0;
                    addr_d[0] = Address;
                    wren_d    = wren;
                    bitCnt_d  = CW'(1);
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (validIn) begin
                    for (int i = 1; i < MemN; i++) begin
                        if (bitCnt_q == CW'(i)) addr_d[i] = Address;
                    end
                    if (bitCnt_q == CW'(ADN - 1)) begin
                        bitCnt_d  = '0;
                        waitCnt_d = '0;
                        state_d   = wren_q ? S_WDATA : S_WAIT;
                    end else begin
                        bitCnt_d = bitCnt_q + CW'(1);
                    end
                end
            end
            S_WDATA: begin
                if (validIn) begin
                    data_d = {DataIn, data_q[N-1:1]};
                    if (bitCnt_q == CW'(N - 1)) begin
                        memWe    = 1'b1;
                        bitCnt_d = '0;
                        state_d  = S_WAIT;
                    end else begin
                        bitCnt_d = bitCnt_q + CW'(1);
                    end
                end
            end
            S_WAIT: begin
                // With DelayN=0 WaitLast is 0 too, so the exit happens on the first WAIT cycle.
                if (waitCnt_q == WW'(WaitLast)) begin
                    if (wren_q) begin
                        state_d = S_IDLE;
                    end else begin
                        rdShift_d = mem_q[addr_q];
                        bitCnt_d  = '0;
                        state_d   = S_RDATA;
                    end
                end else begin
                    waitCnt_d = waitCnt_q + WW'(1);
                end
            end
            S_RDATA: begin
                if (bitCnt_q == CW'(N)) begin
                    state_d = S_IDLE;
                end else if (BusAvailable) begin
                    validOut_d = 1'b1;
                    dataOut_d  = rdShift_q[0];
                    rdShift_d  = rdShift_q >> 1;
                    bitCnt_d   = bitCnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bitCnt_q   <= '0;
            addr_q     <= '0;
            wren_q     <= 1'b0;
            data_q     <= '0;
            waitCnt_q  <= '0;
            rdShift_q  <= '0;
            validOut_q <= 1'b0;
            dataOut_q  <= 1'b0;
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            addr_q     <= addr_d;
            wren_q     <= wren_d;
            data_q     <= data_d;
            waitCnt_q  <= waitCnt_d;
            rdShift_q  <= rdShift_d;
            validOut_q <= validOut_d;
            dataOut_q  <= dataOut_d;
            if (memWe) mem_q[addr_q] <= data_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign validOut  = validOut_q;
    assign DataOut   = dataOut_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_serial_slave_responder.sv
// Drives two responders (DelayN=20 and DelayN=0) with identical serial traffic and checks
// read-back words and timing against a word-level memory model.
module tb_serial_slave_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       validIn = 1'b0;
    logic       wren = 1'b0;
    logic       Address = 1'b0;
    logic       DataIn = 1'b0;
    logic [1:0] ba = 2'b11;
    logic [1:0] rdy;
    logic [1:0] vout;
    logic [1:0] dout;
    logic [3:0] st0, st1;

    int nChecks = 0;
    int nFails  = 0;
    logic [7:0] modelMem [4];
    int effDly [2] = '{20, 1};

    always #5 clk = ~clk;

    serial_slave_responder #(.MemN(2), .N(8), .DelayN(20), .ADN(12)) dutSlow (
        .clk(clk), .reset(reset), .validIn(validIn), .wren(wren), .Address(Address),
        .DataIn(DataIn), .BusAvailable(ba[0]), .ready(rdy[0]), .validOut(vout[0]),
        .DataOut(dout[0]), .state_out(st0)
    );

    serial_slave_responder #(.MemN(2), .N(8), .DelayN(0), .ADN(12)) dutFast (
        .clk(clk), .reset(reset), .validIn(validIn), .wren(wren), .Address(Address),
        .DataIn(DataIn), .BusAvailable(ba[1]), .ready(rdy[1]), .validOut(vout[1]),
        .DataOut(dout[1]), .state_out(st1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int gapLen(input int gapMode);
        if (gapMode < 0) return $urandom_range(0, 2);
        return gapMode;
    endfunction

    task automatic driveJunk(input logic allowValid);
        validIn = allowValid ? 1'($urandom) : 1'b0;
        Address = 1'($urandom);
        DataIn  = 1'($urandom);
        wren    = 1'($urandom);
    endtask

    task automatic applyStimulus(input logic [11:0] a, input logic w, input logic [7:0] d,
                                 input int nData, input int gapMode);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) repeat (gapLen(gapMode)) begin driveJunk(1'b0); tick; end
            validIn = 1'b1;
            Address = a[i];
            DataIn  = 1'($urandom);
            wren    = (i == 0) ? w : 1'($urandom);
            tick;
            if (i == 0) checkOutput("ready_low_first_bit", 32'(rdy), 32'd0);
        end
        for (int i = 0; i < nData; i++) begin
            repeat (gapLen(gapMode)) begin driveJunk(1'b0); tick; end
            validIn = 1'b1;
            DataIn  = d[i];
            Address = 1'($urandom);
            wren    = 1'($urandom);
            tick;
        end
        validIn = 1'b0;
    endtask

    task automatic doWrite(input logic [11:0] a, input logic [7:0] d, input int gapMode);
        int lat [2];
        lat = '{0, 0};
        applyStimulus(a, 1'b1, d, 8, gapMode);
        for (int cyc = 1; cyc <= 300 && (lat[0] == 0 || lat[1] == 0); cyc++) begin
            driveJunk(rdy == 2'b00);
            tick;
            for (int k = 0; k < 2; k++) if (lat[k] == 0 && rdy[k]) lat[k] = cyc;
        end
        validIn = 1'b0;
        for (int k = 0; k < 2; k++)
            checkOutput($sformatf("wr_ready_latency%0d", k), lat[k], effDly[k]);
        modelMem[a[1:0]] = d;
    endtask

    // mode 0: bus always granted; mode 1: 3-cycle grant drop after the 4th bit; mode 2: random grant
    task automatic doRead(input logic [11:0] a, input int mode, input int gapMode);
        int cnt [2], first [2], last [2], readyAt [2], gaps [2], doutErr [2], dropLeft [2];
        logic [7:0] word [2];
        bit done [2];
        for (int k = 0; k < 2; k++) begin
            cnt[k] = 0; first[k] = 0; last[k] = 0; readyAt[k] = 0;
            gaps[k] = 0; doutErr[k] = 0; dropLeft[k] = 0; word[k] = '0; done[k] = 0;
        end
        applyStimulus(a, 1'b0, 8'h00, 0, gapMode);
        for (int cyc = 1; cyc <= 300 && !(done[0] && done[1]); cyc++) begin
            for (int k = 0; k < 2; k++) begin
                if (mode == 2) ba[k] = ($urandom_range(0, 3) != 0);
                else if (dropLeft[k] > 0) begin ba[k] = 1'b0; dropLeft[k]--; end
                else ba[k] = 1'b1;
            end
            driveJunk(rdy == 2'b00);
            tick;
            for (int k = 0; k < 2; k++) begin
                if (!done[k]) begin
                    if (vout[k]) begin
                        if (cnt[k] < 8) word[k][cnt[k]] = dout[k];
                        if (cnt[k] == 0) first[k] = cyc;
                        last[k] = cyc;
                        cnt[k]++;
                        if (mode == 1 && cnt[k] == 4) dropLeft[k] = 3;
                    end else begin
                        if (dout[k]) doutErr[k]++;
                        if (cnt[k] > 0 && cnt[k] < 8) gaps[k]++;
                    end
                    if (rdy[k]) begin done[k] = 1; readyAt[k] = cyc; end
                end
            end
        end
        validIn = 1'b0;
        ba = 2'b11;
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("rd_done%0d", k), 32'(done[k]), 32'd1);
            checkOutput($sformatf("rd_word%0d", k), 32'(word[k]), 32'(modelMem[a[1:0]]));
            checkOutput($sformatf("rd_bitcount%0d", k), cnt[k], 8);
            checkOutput($sformatf("rd_ready_after_last%0d", k), readyAt[k], last[k] + 1);
            checkOutput($sformatf("rd_dout_zero_when_invalid%0d", k), doutErr[k], 0);
            if (mode == 0) begin
                checkOutput($sformatf("rd_first_latency%0d", k), first[k], effDly[k] + 1);
                checkOutput($sformatf("rd_gaps%0d", k), gaps[k], 0);
            end else if (mode == 1) begin
                checkOutput($sformatf("rd_gaps%0d", k), gaps[k], 3);
            end
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_state0"}, 32'(st0), 32'd0);
        checkOutput({tag, "_state1"}, 32'(st1), 32'd0);
        checkOutput({tag, "_ready"}, 32'(rdy), 32'd3);
        checkOutput({tag, "_validOut"}, 32'(vout), 32'd0);
        checkOutput({tag, "_DataOut"}, 32'(dout), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) modelMem[i] = 8'h00;
        reset = 1'b1;
        tick;
        tick;
        checkResetState("reset");
        reset = 1'b0;

        // Directed scenarios from the bring-up plan
        doWrite(12'h002, 8'hA5, 0);
        doRead(12'h002, 0, 0);
        doRead(12'h002, 1, 0);
        doWrite(12'hFF5, 8'h3C, 2);
        doRead(12'h001, 0, 0);
        doWrite(12'h003, 8'hFF, 0);
        doRead(12'h003, 0, 0);

        // Reset in the middle of write data, with validIn high on the same edge
        applyStimulus(12'h002, 1'b1, 8'h5A, 5, 0);
        validIn = 1'b1;
        DataIn  = 1'b1;
        reset   = 1'b1;
        tick;
        checkResetState("midwrite_reset");
        reset   = 1'b0;
        validIn = 1'b0;
        for (int i = 0; i < 4; i++) modelMem[i] = 8'h00;
        doRead(12'h002, 0, 0);
        doRead(12'h003, 0, 0);

        // Randomised traffic
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 1) == 1)
                doWrite(12'($urandom), 8'($urandom), -1);
            else
                doRead(12'($urandom), $urandom_range(0, 2), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
